// File: rtl/bus_b_mux_reg.sv
// Registered bus-B source multiplexer: selects one of 2^SEL_W sources or a zero-extended
// immediate onto a single-entry, ready/valid output register. It also counts accepted
// unmapped selects and completed output handshakes.
module bus_b_mux_reg #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned IMM_W = 8,
    parameter int unsigned IMM_SEL = 10,
    parameter logic [(2**SEL_W)-1:0] MAP_MASK = 16'b0001_0111_1111_1101,
    parameter int unsigned ERR_W = 8,
    localparam int unsigned N_SRC = 2**SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC*DATA_W-1:0] src,
    input  logic [IMM_W-1:0]        imm,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [DATA_W-1:0]       bus,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic [SEL_W-1:0]        last_sel,
    output logic                    err_sticky,
    output logic [ERR_W-1:0]        err_cnt,
    input  logic                    err_clr,
    output logic [15:0]             xfer_cnt
);

    logic [DATA_W-1:0] bus_q, bus_d;
    logic              bus_valid_q, bus_valid_d;
    logic [SEL_W-1:0]  last_sel_q, last_sel_d;
    logic              err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [15:0]       xfer_cnt_q, xfer_cnt_d;

    logic [DATA_W-1:0] src_arr [N_SRC];
    logic [DATA_W-1:0] imm_ext;
    logic              accept;
    logic              sel_mapped;
    logic              sel_is_imm;
    logic              out_hs;

    // Unpack the flattened source vector so the select indexes it directly.
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign src_arr[k] = src[k*DATA_W +: DATA_W];
    end

    assign imm_ext    = DATA_W'(imm);
    assign req_ready  = !bus_valid_q || bus_ready;
    assign accept     = req_valid && req_ready;
    assign sel_mapped = MAP_MASK[sel];
    assign sel_is_imm = (sel == SEL_W'(IMM_SEL));
    assign out_hs     = bus_valid_q && bus_ready;

    // Next-state for the output register, the error tracking and the transfer counter.
    always_comb begin
        bus_d        = bus_q;
        bus_valid_d  = bus_valid_q;
        last_sel_d   = last_sel_q;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        xfer_cnt_d   = xfer_cnt_q;

        if (out_hs) begin
            bus_valid_d = 1'b0;
            xfer_cnt_d  = xfer_cnt_q + 16'd1;
        end

        if (accept) begin
            bus_valid_d = 1'b1;
            last_sel_d  = sel;
            // An unmapped select still produces a transfer, carrying the stale bus value.
            if (sel_mapped) begin
                bus_d = sel_is_imm ? imm_ext : src_arr[sel];
            end
        end

        // A new error outranks a simultaneous clear, leaving the count at one.
        if (accept && !sel_mapped) begin
            err_sticky_d = 1'b1;
            if (err_clr) begin
                err_cnt_d = ERR_W'(1);
            end else if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = '0;
        end
    end

    // State registers with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q        <= '0;
            bus_valid_q  <= 1'b0;
            last_sel_q   <= '0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            xfer_cnt_q   <= '0;
        end else begin
            bus_q        <= bus_d;
            bus_valid_q  <= bus_valid_d;
            last_sel_q   <= last_sel_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            xfer_cnt_q   <= xfer_cnt_d;
        end
    end

    assign bus        = bus_q;
    assign bus_valid  = bus_valid_q;
    assign last_sel   = last_sel_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: doc/bus_b_mux_reg.md
BUS_B_MUX_REG -- requirements
Module: bus_b_mux_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of each source and of the bus.
REQ-002 SHALL have parameter SEL_W, default 4, meaning the select width; the source count is N_SRC = 2^SEL_W.
REQ-003 SHALL have parameter IMM_W, default 8, meaning the immediate (instruction field) width; IMM_W SHALL be <= DATA_W.
REQ-004 SHALL have parameter IMM_SEL, default 10, meaning the select code that routes the zero-extended immediate.
REQ-005 SHALL have parameter MAP_MASK, default 16'b0001_0111_1111_1101, meaning bit k=1 marks select code k as mapped (default maps codes 0, 2-10 and 12).
REQ-006 SHALL have parameter ERR_W, default 8, meaning the illegal-select counter width.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port src, input, N_SRC*DATA_W bits: flattened sources; source k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port imm, input, IMM_W bits: the instruction immediate.
REQ-011 SHALL have port sel, input, SEL_W bits: the source select.
REQ-012 SHALL have port req_valid, input, 1 bit: sel and the sources are presented.
REQ-013 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-014 SHALL have port bus, output, DATA_W bits: the registered bus value.
REQ-015 SHALL have port bus_valid, output, 1 bit: bus holds an undelivered transfer.
REQ-016 SHALL have port bus_ready, input, 1 bit: the consumer takes bus this cycle.
REQ-017 SHALL have port last_sel, output, SEL_W bits: the select of the most recent accepted request.
REQ-018 SHALL have port err_sticky, output, 1 bit: an unmapped select was accepted since the last clear.
REQ-019 SHALL have port err_cnt, output, ERR_W bits: the count of accepted unmapped selects, saturating.
REQ-020 SHALL have port err_clr, input, 1 bit: clears err_sticky and err_cnt.
REQ-021 SHALL have port xfer_cnt, output, 16 bits: the count of completed output handshakes, wrapping.

Function
REQ-022 SHALL drive req_ready = !bus_valid || bus_ready, combinationally; the output stage is single-entry and pipelines at one transfer per cycle.
REQ-023 SHALL treat a cycle with req_valid && req_ready as an accept.
REQ-024 On an accept with a mapped sel != IMM_SEL, SHALL load bus with src[sel] on the next edge; latency from accept to visible output SHALL be 1 cycle.
REQ-025 On an accept with sel == IMM_SEL and that code mapped, SHALL load bus with imm zero-extended to DATA_W.
REQ-026 On an accept with an unmapped sel, SHALL hold bus at its previous value and still set bus_valid=1, so that every request produces exactly one transfer.
REQ-027 On an accept, SHALL set bus_valid=1 and load last_sel with sel.
REQ-028 In a cycle with bus_valid && bus_ready and no accept, SHALL clear bus_valid; with a simultaneous accept, bus_valid SHALL stay 1 and take the new data.
REQ-029 While bus_valid && !bus_ready, bus, bus_valid and last_sel SHALL be stable, and req_ready SHALL be 0.
REQ-030 SHALL increment xfer_cnt on each cycle with bus_valid && bus_ready, wrapping 0xFFFF->0x0000.
REQ-031 On an accept with an unmapped sel, SHALL set err_sticky=1 and increment err_cnt, saturating at 2^ERR_W-1.
REQ-032 On err_clr alone, SHALL zero err_sticky and err_cnt on the next edge.
REQ-033 On err_clr in the same cycle as an unmapped accept, the error SHALL win: err_sticky=1 and err_cnt=1.
REQ-034 SHALL create no combinational path from src, sel or imm to bus; the output is a register only.

Reset
REQ-035 When rst_n=0 at an edge, SHALL set bus=0, bus_valid=0, last_sel=0, err_sticky=0, err_cnt=0 and xfer_cnt=0; req_ready SHALL then read 1.
REQ-036 A reset asserted mid-transfer SHALL discard any undelivered bus value, with no handshake counted.
REQ-037 Reset SHALL take priority over accept, err_clr and output handshakes in the same cycle.

Verification
REQ-038 Reset, then src[3]=0x1234, sel=3, req_valid=1, bus_ready=1 -> next cycle bus=0x1234, bus_valid=1, last_sel=3; the following cycle xfer_cnt=1.
REQ-039 sel=10, imm=0xA5 -> bus=0x00A5.
REQ-040 Load bus=0x1234, then accept sel=1 (unmapped) -> bus stays 0x1234, bus_valid=1, err_sticky=1, err_cnt=1.
REQ-041 Hold bus_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and bus stable; release -> one transfer per cycle, xfer_cnt +1 per cycle.
REQ-042 Issue 260 unmapped accepts -> err_cnt=255; err_clr together with one more unmapped accept -> err_cnt=1, err_sticky=1.
REQ-043 Drive rst_n=0 while bus_valid=1 and bus_ready=0 -> bus_valid=0, xfer_cnt=0, req_ready=1.
